// File: rtl/psk_tx_iq_mapper.sv
// BPSK/QPSK symbol to I/Q mapper with upsampling by SPS.
// Latency: a symbol accepted while idle appears as sample 0 one clock later.
// Backpressure: outputs hold while out_tready is low; the one-entry buffer deasserts sym_in_tready when full.
//
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   mode                      - 0 = BPSK, 1 = QPSK, captured with each accepted symbol
//   sym_in_tdata/tvalid/tready - symbol input stream (QPSK: [1]->I, [0]->Q; BPSK: [0]->I)
//   I_out_*, Q_out_*          - signed I/Q sample stream, shared ready out_tready
//   sym_start                 - marks sample 0 of each symbol
//   underflow                 - one-cycle pulse when the stream runs dry at a symbol boundary
module psk_tx_iq_mapper #(
  parameter int WIDTH      = 16,
  parameter int SHIFT      = 2,
  parameter int SPS        = 8,
  parameter int ZERO_STUFF = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [1:0]              sym_in_tdata,
  input  logic                    sym_in_tvalid,
  output logic                    sym_in_tready,
  output logic signed [WIDTH-1:0] I_out_tdata,
  output logic                    I_out_tvalid,
  output logic signed [WIDTH-1:0] Q_out_tdata,
  output logic                    Q_out_tvalid,
  input  logic                    out_tready,
  output logic                    sym_start,
  output logic                    underflow
);

  localparam int CW = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(SPS - 1);

  // Full-scale positive value backed off by SHIFT; matches the receive-side pre-scaling.
  localparam logic [WIDTH-1:0]        AMP_U = {1'b0, {(WIDTH-1){1'b1}}} >> SHIFT;
  localparam logic signed [WIDTH-1:0] AMP_P = $signed(AMP_U);
  localparam logic signed [WIDTH-1:0] AMP_N = -AMP_P;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state, nxt_state;
  logic [CW-1:0]           cnt, nxt_cnt;
  logic                    buf_valid;
  logic [1:0]              buf_bits;
  logic                    buf_mode;
  logic signed [WIDTH-1:0] cur_i, cur_q, nxt_cur_i, nxt_cur_q;
  logic signed [WIDTH-1:0] nxt_i, nxt_q;
  logic                    out_vld, nxt_vld, nxt_start, nxt_uf;
  logic signed [WIDTH-1:0] map_i, map_q;
  logic                    advance, at_end, load;

  function automatic logic signed [WIDTH-1:0] lvl(input logic b);
    return b ? AMP_N : AMP_P;
  endfunction

  assign I_out_tvalid = out_vld;
  assign Q_out_tvalid = out_vld;

  always_comb begin
    advance       = !out_vld || out_tready;
    at_end        = (state == RUN) && (cnt == LAST);
    load          = advance && buf_valid && ((state == IDLE) || at_end);
    sym_in_tready = !rst && (!buf_valid || load);

    map_i = buf_mode ? lvl(buf_bits[1]) : lvl(buf_bits[0]);
    map_q = buf_mode ? lvl(buf_bits[0]) : '0;

    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_cur_i = cur_i;
    nxt_cur_q = cur_q;
    nxt_i     = I_out_tdata;
    nxt_q     = Q_out_tdata;
    nxt_vld   = out_vld;
    nxt_start = sym_start;
    nxt_uf    = 1'b0;

    if (advance) begin
      if (load) begin
        // Sample 0 of a new symbol; back-to-back loads keep the output gapless.
        nxt_state = RUN;
        nxt_cnt   = '0;
        nxt_cur_i = map_i;
        nxt_cur_q = map_q;
        nxt_i     = map_i;
        nxt_q     = map_q;
        nxt_vld   = 1'b1;
        nxt_start = 1'b1;
      end else if (state == IDLE) begin
        nxt_i     = '0;
        nxt_q     = '0;
        nxt_vld   = 1'b0;
        nxt_start = 1'b0;
      end else if (at_end) begin
        // Symbol finished with nothing queued.
        nxt_state = IDLE;
        nxt_i     = '0;
        nxt_q     = '0;
        nxt_vld   = 1'b0;
        nxt_start = 1'b0;
        nxt_uf    = 1'b1;
      end else begin
        nxt_cnt   = cnt + CW'(1);
        nxt_i     = (ZERO_STUFF != 0) ? '0 : cur_i;
        nxt_q     = (ZERO_STUFF != 0) ? '0 : cur_q;
        nxt_vld   = 1'b1;
        nxt_start = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cur_i       <= '0;
      cur_q       <= '0;
      I_out_tdata <= '0;
      Q_out_tdata <= '0;
      out_vld     <= 1'b0;
      sym_start   <= 1'b0;
      underflow   <= 1'b0;
      buf_valid   <= 1'b0;
      buf_bits    <= '0;
      buf_mode    <= 1'b0;
    end else begin
      state       <= nxt_state;
      cnt         <= nxt_cnt;
      cur_i       <= nxt_cur_i;
      cur_q       <= nxt_cur_q;
      I_out_tdata <= nxt_i;
      Q_out_tdata <= nxt_q;
      out_vld     <= nxt_vld;
      sym_start   <= nxt_start;
      underflow   <= nxt_uf;
      // Drain first so a same-cycle fill wins.
      if (load) buf_valid <= 1'b0;
      if (sym_in_tvalid && sym_in_tready) begin
        buf_valid <= 1'b1;
        buf_bits  <= sym_in_tdata;
        buf_mode  <= mode;
      end
    end
  end

endmodule

// File: tb/tb_psk_tx_iq_mapper.sv
// Directed bench for psk_tx_iq_mapper: three instances cover the default
// configuration, hold-mode SPS=4, and the SPS=1 corner.
module tb_psk_tx_iq_mapper;

  localparam int A = 8191;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [2:0] md, vld, ordy, trdy, ivld, qvld, st, uf;
  logic [1:0] dat [3];
  logic signed [15:0] io [3];
  logic signed [15:0] qo [3];

  int errors = 0;
  int checks = 0;

  logic [1:0] sq [$];
  int fed;
  int ei [$];
  int eq [$];
  int es [$];

  psk_tx_iq_mapper #(.WIDTH(16), .SHIFT(2), .SPS(8), .ZERO_STUFF(1)) u_def (
    .clk(clk), .rst(rst), .mode(md[0]), .sym_in_tdata(dat[0]), .sym_in_tvalid(vld[0]),
    .sym_in_tready(trdy[0]), .I_out_tdata(io[0]), .I_out_tvalid(ivld[0]),
    .Q_out_tdata(qo[0]), .Q_out_tvalid(qvld[0]), .out_tready(ordy[0]),
    .sym_start(st[0]), .underflow(uf[0]));

  psk_tx_iq_mapper #(.WIDTH(16), .SHIFT(2), .SPS(4), .ZERO_STUFF(0)) u_hold (
    .clk(clk), .rst(rst), .mode(md[1]), .sym_in_tdata(dat[1]), .sym_in_tvalid(vld[1]),
    .sym_in_tready(trdy[1]), .I_out_tdata(io[1]), .I_out_tvalid(ivld[1]),
    .Q_out_tdata(qo[1]), .Q_out_tvalid(qvld[1]), .out_tready(ordy[1]),
    .sym_start(st[1]), .underflow(uf[1]));

  psk_tx_iq_mapper #(.WIDTH(16), .SHIFT(2), .SPS(1), .ZERO_STUFF(1)) u_sps1 (
    .clk(clk), .rst(rst), .mode(md[2]), .sym_in_tdata(dat[2]), .sym_in_tvalid(vld[2]),
    .sym_in_tready(trdy[2]), .I_out_tdata(io[2]), .I_out_tvalid(ivld[2]),
    .Q_out_tdata(qo[2]), .Q_out_tvalid(qvld[2]), .out_tready(ordy[2]),
    .sym_start(st[2]), .underflow(uf[2]));

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    sq.delete(); ei.delete(); eq.delete(); es.delete();
  endtask

  task automatic push(input int i, input int q, input int s);
    ei.push_back(i); eq.push_back(q); es.push_back(s);
  endtask

  task automatic push_zeros(input int n);
    for (int j = 0; j < n; j++) push(0, 0, 0);
  endtask

  // Feeds sq into instance k and checks every accepted output sample against ei/eq/es.
  task automatic stream(input int k, input int stall_at, input int stall_len, input bit rdy_high);
    int idx = 0;
    int cyc = 0;
    int stall = stall_len;
    int acc_cyc = -1;
    int vld_cyc = -1;
    bit started = 1'b0;
    int n = ei.size();
    fed = 0;
    while (idx < n && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (ivld[k] && !started) begin
        started = 1'b1;
        vld_cyc = cyc;
      end
      if (started) begin
        chk("gapless_vld", 32'(ivld[k]), 1);
        chk("q_vld_eq_i_vld", 32'(qvld[k]), 32'(ivld[k]));
        chk("no_underflow", 32'(uf[k]), 0);
        chk($sformatf("I[%0d]", idx), 32'(io[k]), ei[idx]);
        chk($sformatf("Q[%0d]", idx), 32'(qo[k]), eq[idx]);
        chk($sformatf("start[%0d]", idx), 32'(st[k]), es[idx]);
      end
      if (stall > 0 && idx == stall_at) begin
        ordy[k] = 1'b0;
        stall--;
      end else begin
        ordy[k] = 1'b1;
      end
      if (fed < sq.size()) begin
        vld[k] = 1'b1;
        dat[k] = sq[fed];
      end else begin
        vld[k] = 1'b0;
      end
      #1;
      if (!ordy[k]) chk("rdy_low_when_full", 32'(trdy[k]), 0);
      if (rdy_high) chk("rdy_stays_high", 32'(trdy[k]), 1);
      if (vld[k] && trdy[k]) begin
        if (acc_cyc < 0) acc_cyc = cyc;
        fed++;
      end
      if (ivld[k] && ordy[k]) idx++;
    end
    vld[k] = 1'b0;
    chk("samples_done", idx, n);
    chk("first_latency", vld_cyc - acc_cyc, 2);
    chk("all_fed", fed, sq.size());
  endtask

  task automatic tail(input int k);
    @(negedge clk);
    chk("end_vld", 32'(ivld[k]), 0);
    chk("uf_pulse", 32'(uf[k]), 1);
    @(negedge clk);
    chk("uf_once", 32'(uf[k]), 0);
  endtask

  task automatic check_zero(input int k, input string tag);
    chk({tag, "_I"}, 32'(io[k]), 0);
    chk({tag, "_Q"}, 32'(qo[k]), 0);
    chk({tag, "_ivld"}, 32'(ivld[k]), 0);
    chk({tag, "_qvld"}, 32'(qvld[k]), 0);
    chk({tag, "_start"}, 32'(st[k]), 0);
    chk({tag, "_uf"}, 32'(uf[k]), 0);
  endtask

  initial begin
    // Reset with valid input asserted: ready held low, outputs cleared.
    rst  = 1'b1;
    vld  = 3'b111;
    md   = 3'b111;
    ordy = 3'b111;
    for (int k = 0; k < 3; k++) dat[k] = 2'b11;
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        check_zero(k, "rst");
        chk("rst_rdy", 32'(trdy[k]), 0);
      end
    end
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk("rdy_after_rst", 32'(trdy[k]), 1);
    vld = 3'b000;

    // Single QPSK symbol 2'b10, zero-stuffed to 8 samples.
    clr();
    md[0] = 1'b1;
    sq.push_back(2'b10);
    push(-A, A, 1);
    push_zeros(7);
    stream(0, -1, 0, 1'b0);
    tail(0);

    // BPSK hold mode, SPS=4: symbols 1,0,1.
    clr();
    md[1] = 1'b0;
    sq.push_back(2'b01); sq.push_back(2'b00); sq.push_back(2'b01);
    for (int j = 0; j < 4; j++) push(-A, 0, (j == 0) ? 1 : 0);
    for (int j = 0; j < 4; j++) push(A, 0, (j == 0) ? 1 : 0);
    for (int j = 0; j < 4; j++) push(-A, 0, (j == 0) ? 1 : 0);
    stream(1, -1, 0, 1'b0);
    tail(1);

    // Backpressure: 5-cycle stall on sample 2 with the buffer full.
    clr();
    md[0] = 1'b1;
    sq.push_back(2'b00); sq.push_back(2'b11);
    push(A, A, 1);
    push_zeros(7);
    push(-A, -A, 1);
    push_zeros(7);
    stream(0, 2, 5, 1'b0);
    tail(0);

    // SPS=1: four back-to-back QPSK symbols.
    clr();
    md[2] = 1'b1;
    sq.push_back(2'b00); sq.push_back(2'b01); sq.push_back(2'b11); sq.push_back(2'b10);
    push(A, A, 1);
    push(A, -A, 1);
    push(-A, -A, 1);
    push(-A, A, 1);
    stream(2, -1, 0, 1'b1);
    tail(2);

    // Reset at sample 3 of a symbol with another symbol buffered.
    clr();
    md[0] = 1'b1;
    sq.push_back(2'b01); sq.push_back(2'b10);
    push(A, -A, 1);
    push_zeros(3);
    stream(0, -1, 0, 1'b0);
    chk("buf_full_before_rst", 32'(trdy[0]), 0);
    rst = 1'b1;
    #1;
    chk("rdy_forced_low", 32'(trdy[0]), 0);
    @(negedge clk);
    check_zero(0, "mid_rst");
    chk("mid_rst_rdy", 32'(trdy[0]), 0);
    rst = 1'b0;
    #1;
    chk("rdy_after_mid_rst", 32'(trdy[0]), 1);
    clr();
    sq.push_back(2'b11);
    push(-A, -A, 1);
    push_zeros(7);
    stream(0, -1, 0, 1'b0);
    tail(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
